// File: rtl/rns_crt_recon.sv
// RNS -> binary reconstruction via the Chinese Remainder Theorem.
// Residues arrive serially, channel 0 first. The weighted residues are
// accumulated one channel per cycle, then reduced modulo M by repeated
// subtraction. The result is held until the consumer takes it.
module rns_crt_recon #(
  parameter int PARTS  = 3,
  parameter int SWIDTH = 8,
  parameter int LWIDTH = 24,
  parameter int Q0     = 251,
  parameter int Q1     = 241,
  parameter int Q2     = 239
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SWIDTH-1:0] r_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LWIDTH-1:0] x_out,
  output logic              out_err
);

  localparam int ACCW = LWIDTH + $clog2(PARTS);
  localparam int CW   = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int PW   = 2 * SWIDTH;

  function automatic longint unsigned q_of(input int i);
    case (i)
      0:       return longint'(Q0);
      1:       return longint'(Q1);
      default: return longint'(Q2);
    endcase
  endfunction

  function automatic longint unsigned calc_m();
    longint unsigned m;
    m = 1;
    for (int i = 0; i < PARTS; i++) m = m * q_of(i);
    return m;
  endfunction

  function automatic longint unsigned calc_mi(input int i);
    return calc_m() / q_of(i);
  endfunction

  // Modular inverse of M_i modulo Q_i by exhaustive search (elaboration only).
  function automatic longint unsigned calc_yi(input int i);
    longint unsigned q, mr;
    q  = q_of(i);
    mr = calc_mi(i) % q;
    for (longint unsigned y = 1; y < q; y++)
      if (((mr * y) % q) == 1) return y;
    return 0;
  endfunction

  localparam logic [ACCW-1:0] M_ACC = ACCW'(calc_m());

  typedef enum logic [1:0] {COLLECT, MAC, REDUCE, OUTPUT} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ACCW-1:0]   r_acc;
  logic              r_err;
  logic              r_out_valid;
  logic [LWIDTH-1:0] r_x_out;
  logic              r_out_err;
  logic [SWIDTH-1:0] r_buf [PARTS];

  logic [SWIDTH-1:0] w_q    [PARTS];
  logic [ACCW-1:0]   w_term [PARTS];
  logic              w_last;

  // Per-channel constants and weighted residue ((buf*Y) mod Q) * M_i.
  for (genvar g = 0; g < PARTS; g++) begin : g_chan
    localparam logic [SWIDTH-1:0] QG = SWIDTH'(q_of(g));
    localparam logic [SWIDTH-1:0] YG = SWIDTH'(calc_yi(g));
    localparam logic [LWIDTH-1:0] MG = LWIDTH'(calc_mi(g));
    logic [PW-1:0]     w_prod;
    logic [SWIDTH-1:0] w_red;
    assign w_q[g]    = QG;
    assign w_prod    = PW'(r_buf[g]) * PW'(YG);
    assign w_red     = SWIDTH'(w_prod % PW'(QG));
    assign w_term[g] = ACCW'(w_red) * ACCW'(MG);
  end

  assign w_last    = (r_cnt == CW'(PARTS - 1));
  assign in_ready  = (r_state == COLLECT) && !reset;
  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;
  assign out_err   = r_out_err;

  // Residue buffer: data only, written on each accepted residue.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) r_buf[r_cnt] <= r_in;
  end

  // Control FSM: collect, accumulate, reduce mod M, present result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_x_out     <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            if (r_in >= w_q[r_cnt]) r_err <= 1'b1;
            if (w_last) begin
              r_cnt   <= '0;
              r_acc   <= '0;
              r_state <= MAC;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        MAC: begin
          r_acc <= r_acc + w_term[r_cnt];
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= REDUCE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REDUCE: begin
          if (r_acc >= M_ACC) begin
            r_acc <= r_acc - M_ACC;
          end else begin
            r_state     <= OUTPUT;
            r_out_valid <= 1'b1;
            r_x_out     <= r_err ? '0 : r_acc[LWIDTH-1:0];
            r_out_err   <= r_err;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_crt_recon.sv
// Self-checking bench for rns_crt_recon: directed table, reset corner
// cases and randomized frames against a CRT search model.
module tb_rns_crt_recon;

  localparam int PARTS  = 3;
  localparam int SWIDTH = 8;
  localparam int LWIDTH = 24;
  localparam int QA = 251, QB = 241, QC = 239;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [SWIDTH-1:0] r_in;
  logic              out_valid;
  logic              out_ready;
  logic [LWIDTH-1:0] x_out;
  logic              out_err;

  int checks = 0;
  int failures = 0;

  rns_crt_recon #(
    .PARTS(PARTS), .SWIDTH(SWIDTH), .LWIDTH(LWIDTH),
    .Q0(QA), .Q1(QB), .Q2(QC)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r0, r1, r2;
    int hold;
    int exp_x;
    int exp_err;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: out-of-range residue -> error; otherwise find the unique
  // x < M with the given residues by stepping through x = r0 + QA*t.
  task automatic ref_model(input int r0, r1, r2, output int x, output int e);
    x = 0;
    e = 0;
    if (r0 >= QA || r1 >= QB || r2 >= QC) begin
      e = 1;
      return;
    end
    for (int t = 0; t < QB * QC; t++) begin
      int c;
      c = r0 + QA * t;
      if ((c % QB) == r1 && (c % QC) == r2) begin
        x = c;
        return;
      end
    end
  endtask

  task automatic feed(input int r);
    in_valid = 1'b1;
    r_in     = SWIDTH'(r);
    chk("in_ready_collect", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Feed one frame, wait for the result, optionally stall, then take it.
  task automatic run_frame(input int r0, r1, r2, hold, exp_x, exp_err);
    int lat;
    logic [LWIDTH-1:0] x0;
    feed(r0);
    feed(r1);
    feed(r2);
    lat = 0;
    while (!out_valid && lat < 20) begin
      out_ready = lat[0];
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    chk("latency_in_range", (lat >= PARTS + 1 && lat <= 2 * PARTS) ? 1 : 0, 1);
    chk("out_valid", out_valid, 1);
    chk("x_out", x_out, exp_x);
    chk("out_err", out_err, exp_err);
    x0 = x_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      r_in     = 8'd7;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_x", x_out, x0);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("err_drop", out_err, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("in_ready_in_reset", in_ready, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("in_ready_post_reset", in_ready, 1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{r0:0,   r1:0,   r2:0,   hold:0,  exp_x:0,        exp_err:0};
    vecs[1] = '{r0:247, r1:36,  r2:44,  hold:0,  exp_x:1000,     exp_err:0};
    vecs[2] = '{r0:250, r1:240, r2:238, hold:0,  exp_x:14457348, exp_err:0};
    vecs[3] = '{r0:1,   r1:1,   r2:1,   hold:10, exp_x:1,        exp_err:0};
    vecs[4] = '{r0:251, r1:0,   r2:0,   hold:0,  exp_x:0,        exp_err:1};
    vecs[5] = '{r0:1,   r1:1,   r2:1,   hold:0,  exp_x:1,        exp_err:0};
    vecs[6] = '{r0:0,   r1:241, r2:0,   hold:2,  exp_x:0,        exp_err:1};
    vecs[7] = '{r0:3,   r1:7,   r2:255, hold:0,  exp_x:0,        exp_err:1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r_in      = '0;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].hold,
                vecs[i].exp_x, vecs[i].exp_err);

    // Reset after two of three residues discards the partial frame.
    feed(250);
    feed(240);
    do_reset();
    run_frame(247, 36, 44, 0, 1000, 0);

    // Reset during accumulate/reduce discards the frame in flight.
    feed(250);
    feed(240);
    feed(238);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    run_frame(1, 1, 1, 0, 1, 0);

    // Reset with an error pending clears the sticky flag.
    feed(255);
    do_reset();
    run_frame(0, 0, 0, 0, 0, 0);

    // Randomized frames, mostly legal residues, some out of range.
    for (int n = 0; n < 40; n++) begin
      int a, b, c, ex, ee;
      if ($urandom_range(7) == 0) begin
        a = $urandom_range(255);
        b = $urandom_range(255);
        c = $urandom_range(255);
      end else begin
        a = $urandom_range(QA - 1);
        b = $urandom_range(QB - 1);
        c = $urandom_range(QC - 1);
      end
      ref_model(a, b, c, ex, ee);
      run_frame(a, b, c, $urandom_range(2), ex, ee);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rns_crt_recon.md
RNS_CRT_RECON -- requirements
Module: rns_crt_recon

Interface
REQ-001 SHALL provide parameters (name, default, meaning): PARTS, 3, number of residue channels.
REQ-002 SWIDTH, 8, residue/modulus width in bits.
REQ-003 LWIDTH, 24, reconstructed integer width in bits.
REQ-004 Q0/Q1/Q2, 251/241/239, pairwise-coprime moduli, one per channel; M = product of all Q_i < 2^LWIDTH.
REQ-005 SHALL derive M, M_i = M/Q_i and Y_i = M_i^-1 mod Q_i at elaboration via constant functions; no runtime inputs for these values.
REQ-006 Ports (name, direction, width, meaning):
clk  input  1  single clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  r_in holds a valid residue.
in_ready  output  1  block accepts a residue this cycle.
r_in  input  SWIDTH  residue, channel 0 first, then 1 .. PARTS-1.
out_valid  output  1  x_out/out_err valid.
out_ready  input  1  consumer accepts the result.
x_out  output  LWIDTH  reconstructed integer, 0 <= x_out < M.
out_err  output  1  one or more residues of this frame were >= their modulus.

Function
REQ-007 State machine states: COLLECT, MAC, REDUCE, OUTPUT; reset enters COLLECT.
REQ-008 COLLECT: in_ready=1; transfer on in_valid && in_ready; residue stored in buffer slot CNT; CNT increments.
REQ-009 On the transfer with CNT == PARTS-1: CNT clears, accumulator ACC clears, state -> MAC on the next edge.
REQ-010 At any transfer where r_in >= Q_CNT: set the sticky frame error flag; r_in still stored.
REQ-011 MAC: one channel per cycle, i = 0 .. PARTS-1: ACC <= ACC + ((buf[i]*Y_i) mod Q_i) * M_i; after PARTS cycles -> REDUCE.
REQ-012 ACC width SHALL be LWIDTH + clog2(PARTS) bits; intermediate products sized to avoid truncation.
REQ-013 REDUCE: each cycle, if ACC >= M then ACC <= ACC - M and stay; else -> OUTPUT. At most PARTS-1 subtractions.
REQ-014 OUTPUT: out_valid=1, x_out=ACC[LWIDTH-1:0], out_err=frame error flag; hold all three stable until out_ready.
REQ-015 If the frame error flag is set, x_out SHALL be 0 and out_err SHALL be 1.
REQ-016 out_valid && out_ready: out_valid and out_err drop on the next edge; error flag clears; state -> COLLECT.
REQ-017 in_ready SHALL be 0 in MAC, REDUCE and OUTPUT. No new frame is accepted until the current result is taken.
REQ-018 Latency from the last-residue accept edge to the out_valid rising edge = PARTS + k + 1 cycles, k = number of REDUCE subtractions (0 <= k <= PARTS-1).
REQ-019 out_ready while out_valid=0 SHALL have no effect. in_valid outside COLLECT SHALL be ignored.
REQ-020 Back-to-back frames: the first residue of a new frame may be accepted on the cycle after the out_valid/out_ready handshake.

Reset
REQ-021 While reset=1 on a rising edge: state=COLLECT, CNT=0, ACC=0, error flag=0, out_valid=0, x_out=0, out_err=0.
REQ-022 Reset in any state, including mid-frame or mid-REDUCE, SHALL discard the partial frame. The next accepted residue is channel 0.
REQ-023 in_ready SHALL be 0 during the reset cycle and 1 on the first cycle after reset deasserts.

Verification
REQ-024 Residues 0,0,0 -> x_out=0, out_err=0.
REQ-025 Residues 247,36,44 -> x_out=1000.
REQ-026 Residues 250,240,238 -> x_out=14457348 (M-1). Measured latency lies within PARTS+1 .. 2*PARTS cycles.
REQ-027 Residues 1,1,1 with out_ready held low 10 cycles -> out_valid and x_out=1 stable all 10 cycles; in_ready=0 throughout.
REQ-028 Residues 251,0,0 -> out_err=1, x_out=0. The following frame 1,1,1 -> out_err=0, x_out=1.
REQ-029 Reset asserted after 2 of 3 residues, then frame 247,36,44 -> x_out=1000.
